exc_ctrl: RTL and testbench

- Exception/interrupt controller for the 5-stage MIPS core.
- Collects per-instruction exception flags at the MEM boundary: ID-decoded syscall, break and eret, plus RI, overflow, address error and hardware interrupts.
- Selects one flag by fixed priority and updates the CP0 exception registers (Status, Cause, EPC, BadVAddr).
- Sequences the pipeline flush and the PC redirect to the exception vector or EPC.

---
 rtl/exc_ctrl_if.sv | 50 +++++
 rtl/exc_ctrl.sv | 157 +++++++++++++++
 tb/tb_exc_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: MEM-stage exception flags, CP0 mtc0/mfc0 bus and flush/redirect
// outputs of the exception controller. slave = controller, master = pipeline.
interface exc_ctrl_if;
    logic        stall_in;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_delay_slot;
    logic        syscall_flag;
    logic        break_flag;
    logic        eret_flag;
    logic        ri_flag;
    logic        ov_flag;
    logic        adel_flag;
    logic        ades_flag;
    logic [31:0] bad_addr;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] epc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] badvaddr;

    modport slave (
        input  stall_in, mem_valid, mem_pc, mem_delay_slot,
        input  syscall_flag, break_flag, eret_flag,
        input  ri_flag, ov_flag, adel_flag, ades_flag,
        input  bad_addr, hw_int,
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, flush, redirect_valid, redirect_pc, busy,
        output epc, status, cause, badvaddr
    );

    modport master (
        output stall_in, mem_valid, mem_pc, mem_delay_slot,
        output syscall_flag, break_flag, eret_flag,
        output ri_flag, ov_flag, adel_flag, ades_flag,
        output bad_addr, hw_int,
        output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, flush, redirect_valid, redirect_pc, busy,
        input  epc, status, cause, badvaddr
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: MIPS exception/interrupt controller at the MEM boundary.
// Ports: clk, rst_n (async, active low), bus (exc_ctrl_if.slave): MEM flags in,
// CP0 read/write bus, flush/redirect/busy and CP0 register state out.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] STATUS_RST   = 32'h0040_0000
) (
    input logic       clk,
    input logic       rst_n,
    exc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_target;

    logic        w_int_req;
    logic        w_any;
    logic        w_accept;
    logic        w_is_eret;
    logic        w_is_addr;
    logic [4:0]  w_code;

    // Interrupts only when globally enabled and not already in an exception.
    assign w_int_req = r_status[0] & ~r_status[1]
                     & (|(r_cause[15:8] & r_status[15:8]));

    assign w_any = w_int_req | bus.adel_flag | bus.ades_flag
                 | bus.ri_flag | bus.ov_flag | bus.syscall_flag
                 | bus.break_flag | bus.eret_flag;

    assign w_accept = (r_state == S_IDLE) & ~bus.stall_in
                    & bus.mem_valid & w_any;

    // Fixed-priority winner; eret is lowest and carries no ExcCode.
    always_comb begin
        w_code    = 5'd0;
        w_is_eret = 1'b0;
        w_is_addr = 1'b0;
        if (w_int_req) begin
            w_code = 5'd0;
        end else if (bus.adel_flag) begin
            w_code    = 5'd4;
            w_is_addr = 1'b1;
        end else if (bus.ades_flag) begin
            w_code    = 5'd5;
            w_is_addr = 1'b1;
        end else if (bus.ri_flag) begin
            w_code = 5'd10;
        end else if (bus.ov_flag) begin
            w_code = 5'd12;
        end else if (bus.syscall_flag) begin
            w_code = 5'd8;
        end else if (bus.break_flag) begin
            w_code = 5'd9;
        end else begin
            w_is_eret = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FLUSH;
            S_FLUSH: if (r_cnt == 3'd1) w_next = S_REDIR;
            S_REDIR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_target <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt    <= 3'(FLUSH_CYCLES);
                r_target <= w_is_eret ? r_epc : EXC_VECTOR;
            end else if (r_state == S_FLUSH && r_cnt != 3'd1) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // mtc0 first; the exception update later in the block overrides
    // any field both of them touch in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status   <= STATUS_RST;
            r_cause    <= 32'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            r_cause[15:10] <= bus.hw_int;
            if (bus.cp0_we) begin
                case (bus.cp0_waddr)
                    5'd12: begin
                        r_status[15:8] <= bus.cp0_wdata[15:8];
                        r_status[1:0]  <= bus.cp0_wdata[1:0];
                    end
                    5'd13: r_cause[9:8] <= bus.cp0_wdata[9:8];
                    5'd14: r_epc <= bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (w_accept) begin
                if (w_is_eret) begin
                    r_status[1] <= 1'b0;
                end else begin
                    if (!r_status[1]) begin
                        r_epc <= bus.mem_delay_slot ? bus.mem_pc - 32'd4
                                                    : bus.mem_pc;
                        r_cause[31] <= bus.mem_delay_slot;
                    end
                    r_status[1]  <= 1'b1;
                    r_cause[6:2] <= w_code;
                    if (w_is_addr) r_badvaddr <= bus.bad_addr;
                end
            end
        end
    end

    assign bus.flush          = (r_state != S_IDLE);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.redirect_valid = (r_state == S_REDIR);
    assign bus.redirect_pc    = (r_state == S_REDIR) ? r_target : 32'd0;

    assign bus.epc      = r_epc;
    assign bus.status   = r_status;
    assign bus.cause    = r_cause;
    assign bus.badvaddr = r_badvaddr;

    always_comb begin
        case (bus.cp0_raddr)
            5'd8:    bus.cp0_rdata = r_badvaddr;
            5'd12:   bus.cp0_rdata = r_status;
            5'd13:   bus.cp0_rdata = r_cause;
            5'd14:   bus.cp0_rdata = r_epc;
            default: bus.cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed vector table, hand sequences and random stimulus
// for exc_ctrl, all checked against a transaction-level CP0 model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC    = 32'hBFC0_0380;
    localparam logic [31:0] ST_RST = 32'h0040_0000;
    localparam int          F      = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    exc_ctrl_if bus();

    exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .FLUSH_CYCLES(F),
        .STATUS_RST  (ST_RST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: CP0 registers plus "cycles of busy left" after the edge.
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_tgt;
    int          m_rem;
    int          codes[7] = '{0, 4, 5, 10, 12, 8, 9};

    typedef struct {
        logic [6:0]  flg;
        logic [31:0] pre_st;
        logic [31:0] pre_epc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [4:0]  x_code;
        logic [31:0] x_epc;
        logic        x_bd;
        logic        x_exl;
        logic [31:0] x_tgt;
        logic [31:0] x_bad;
    } vec_t;

    vec_t vt[7];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_status = ST_RST;
        m_cause  = 32'd0;
        m_epc    = 32'd0;
        m_bad    = 32'd0;
        m_tgt    = 32'd0;
        m_rem    = 0;
    endtask

    function automatic logic [31:0] model_read(logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0]  req;
        logic [31:0] ns, nc, ne, nb;
        logic        ir;
        int          win;
        ir  = m_status[0] && !m_status[1]
              && ((m_cause[15:8] & m_status[15:8]) != 8'd0);
        req = {bus.eret_flag, bus.break_flag, bus.syscall_flag,
               bus.ov_flag, bus.ri_flag, bus.ades_flag,
               bus.adel_flag, ir};
        ns = m_status;
        nc = m_cause;
        ne = m_epc;
        nb = m_bad;
        nc[15:10] = bus.hw_int;
        if (bus.cp0_we) begin
            if (bus.cp0_waddr == 5'd12)
                ns = (ns & ~32'h0000_FF03) | (bus.cp0_wdata & 32'h0000_FF03);
            else if (bus.cp0_waddr == 5'd13)
                nc[9:8] = bus.cp0_wdata[9:8];
            else if (bus.cp0_waddr == 5'd14)
                ne = bus.cp0_wdata;
        end
        if (m_rem > 0) m_rem--;
        else if (!bus.stall_in && bus.mem_valid && req != 8'd0) begin
            win = 0;
            while (!req[win]) win++;
            if (win == 7) begin
                ns[1] = 1'b0;
                m_tgt = m_epc;
            end else begin
                if (!m_status[1]) begin
                    ne = bus.mem_delay_slot ? bus.mem_pc - 32'd4 : bus.mem_pc;
                    nc[31] = bus.mem_delay_slot;
                end
                ns[1]   = 1'b1;
                nc[6:2] = 5'(codes[win]);
                if (win == 1 || win == 2) nb = bus.bad_addr;
                m_tgt = VEC;
            end
            m_rem = F + 1;
        end
        m_status = ns;
        m_cause  = nc;
        m_epc    = ne;
        m_bad    = nb;
    endtask

    task automatic check_all();
        chk("flush", 32'(bus.flush), 32'(m_rem > 0));
        chk("busy", 32'(bus.busy), 32'(m_rem > 0));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rem == 1));
        chk("redirect_pc", bus.redirect_pc, (m_rem == 1) ? m_tgt : 32'd0);
        chk("status", bus.status, m_status);
        chk("cause", bus.cause, m_cause);
        chk("epc", bus.epc, m_epc);
        chk("badvaddr", bus.badvaddr, m_bad);
        chk("cp0_rdata", bus.cp0_rdata, model_read(bus.cp0_raddr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic clr_in();
        bus.stall_in       = 1'b0;
        bus.mem_valid      = 1'b0;
        bus.mem_pc         = 32'd0;
        bus.mem_delay_slot = 1'b0;
        bus.syscall_flag   = 1'b0;
        bus.break_flag     = 1'b0;
        bus.eret_flag      = 1'b0;
        bus.ri_flag        = 1'b0;
        bus.ov_flag        = 1'b0;
        bus.adel_flag      = 1'b0;
        bus.ades_flag      = 1'b0;
        bus.bad_addr       = 32'd0;
        bus.cp0_we         = 1'b0;
        bus.cp0_waddr      = 5'd0;
        bus.cp0_wdata      = 32'd0;
    endtask

    task automatic do_reset();
        clr_in();
        bus.hw_int = 6'd0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic mtc0(logic [4:0] a, logic [31:0] d);
        bus.cp0_we    = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        tick();
        bus.cp0_we = 1'b0;
    endtask

    task automatic run_vec(vec_t v, int idx);
        int cyc;
        do_reset();
        mtc0(5'd12, v.pre_st);
        mtc0(5'd14, v.pre_epc);
        {bus.eret_flag, bus.break_flag, bus.syscall_flag, bus.ov_flag,
         bus.ri_flag, bus.ades_flag, bus.adel_flag} = v.flg;
        bus.mem_valid      = 1'b1;
        bus.mem_pc         = v.pc;
        bus.mem_delay_slot = v.ds;
        bus.bad_addr       = v.bad;
        tick();
        clr_in();
        chk($sformatf("v%0d_code", idx), 32'(bus.cause[6:2]), 32'(v.x_code));
        chk($sformatf("v%0d_epc", idx), bus.epc, v.x_epc);
        chk($sformatf("v%0d_bd", idx), 32'(bus.cause[31]), 32'(v.x_bd));
        chk($sformatf("v%0d_exl", idx), 32'(bus.status[1]), 32'(v.x_exl));
        chk($sformatf("v%0d_bad", idx), bus.badvaddr, v.x_bad);
        cyc = 1;
        while (!bus.redirect_valid && cyc < 8) begin
            tick();
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(F + 1));
        chk($sformatf("v%0d_target", idx), bus.redirect_pc, v.x_tgt);
        tick();
        chk($sformatf("v%0d_idle", idx), 32'(bus.busy), 32'd0);
    endtask

    logic [4:0] ra[5] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd3};

    initial begin
        int nred;
        clr_in();
        bus.hw_int    = 6'd0;
        bus.cp0_raddr = 5'd12;

        vt[0] = '{7'b0010000, 32'h0, 32'h0, 32'h8000_0100, 1'b0, 32'h0,
                  5'd8, 32'h8000_0100, 1'b0, 1'b1, VEC, 32'h0};
        vt[1] = '{7'b0101000, 32'h0, 32'h0, 32'h8000_0208, 1'b1, 32'h0,
                  5'd12, 32'h8000_0204, 1'b1, 1'b1, VEC, 32'h0};
        vt[2] = '{7'b1000000, 32'h2, 32'h8000_0040, 32'h8000_0500, 1'b0,
                  32'h0, 5'd0, 32'h8000_0040, 1'b0, 1'b0, 32'h8000_0040,
                  32'h0};
        vt[3] = '{7'b0000101, 32'h0, 32'h0, 32'h8000_0300, 1'b0,
                  32'h1234_5679, 5'd4, 32'h8000_0300, 1'b0, 1'b1, VEC,
                  32'h1234_5679};
        vt[4] = '{7'b0010010, 32'h0, 32'h0, 32'h8000_0304, 1'b1,
                  32'hCAFE_0002, 5'd5, 32'h8000_0300, 1'b1, 1'b1, VEC,
                  32'hCAFE_0002};
        vt[5] = '{7'b0010100, 32'h2, 32'h8000_0040, 32'h8000_0400, 1'b1,
                  32'hDEAD_BEEF, 5'd10, 32'h8000_0040, 1'b0, 1'b1, VEC,
                  32'h0};
        vt[6] = '{7'b1100000, 32'h0, 32'h0, 32'h8000_0600, 1'b0, 32'h0,
                  5'd9, 32'h8000_0600, 1'b0, 1'b1, VEC, 32'h0};

        do_reset();
        chk("rst_status", bus.status, ST_RST);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vt[i], i);
            if (i == 2) chk("eret_status", bus.status, ST_RST);
        end

        // Hardware interrupt with IE=1, IM2=1.
        do_reset();
        mtc0(5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001;
        tick();
        chk("int_ip2", 32'(bus.cause[10]), 32'd1);
        bus.mem_valid = 1'b1;
        tick();
        chk("int_busy", 32'(bus.busy), 32'd1);
        chk("int_code", 32'(bus.cause[6:2]), 32'd0);
        chk("int_exl", 32'(bus.status[1]), 32'd1);
        bus.mem_valid = 1'b0;
        bus.hw_int    = 6'd0;
        for (int i = 0; i < 3; i++) tick();

        // Same interrupt with EXL already set: never taken.
        do_reset();
        mtc0(5'd12, 32'h0000_0403);
        bus.hw_int    = 6'b000001;
        bus.mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("int_exl_blocked", 32'(bus.busy), 32'd0);
        bus.hw_int    = 6'd0;
        bus.mem_valid = 1'b0;

        // syscall held under stall, then through the busy window.
        do_reset();
        bus.syscall_flag = 1'b1;
        bus.mem_valid    = 1'b1;
        bus.stall_in     = 1'b1;
        tick();
        chk("stall_blocks", 32'(bus.busy), 32'd0);
        bus.stall_in = 1'b0;
        tick();
        chk("accept_after_stall", 32'(bus.busy), 32'd1);
        bus.stall_in = 1'b1;
        nred = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.redirect_valid) begin
                nred++;
                bus.syscall_flag = 1'b0;
                bus.mem_valid    = 1'b0;
            end
        end
        chk("single_redirect", 32'(nred), 32'd1);
        bus.stall_in = 1'b0;

        // Reset asserted while flushing drops the pending redirect.
        do_reset();
        bus.syscall_flag = 1'b1;
        bus.mem_valid    = 1'b1;
        tick();
        clr_in();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_mid_flush", 32'(bus.flush), 32'd0);
        chk("rst_mid_status", bus.status, ST_RST);
        #2;
        rst_n = 1'b1;
        nred = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.redirect_valid) nred++;
        end
        chk("no_redirect_after_rst", 32'(nred), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.mem_valid      = ($urandom_range(0, 9) < 8);
            bus.stall_in       = ($urandom_range(0, 9) < 2);
            bus.mem_pc         = $urandom & 32'hFFFF_FFFC;
            bus.mem_delay_slot = 1'($urandom_range(0, 1));
            bus.syscall_flag   = ($urandom_range(0, 19) == 0);
            bus.break_flag     = ($urandom_range(0, 19) == 0);
            bus.eret_flag      = ($urandom_range(0, 19) == 0);
            bus.ri_flag        = ($urandom_range(0, 19) == 0);
            bus.ov_flag        = ($urandom_range(0, 19) == 0);
            bus.adel_flag      = ($urandom_range(0, 19) == 0);
            bus.ades_flag      = ($urandom_range(0, 19) == 0);
            bus.bad_addr       = $urandom;
            if ($urandom_range(0, 9) == 0) bus.hw_int = 6'($urandom);
            bus.cp0_we    = ($urandom_range(0, 9) == 0);
            bus.cp0_waddr = ra[$urandom_range(0, 4)];
            bus.cp0_wdata = $urandom;
            bus.cp0_raddr = ra[$urandom_range(0, 4)];
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
